// File: rtl/alu_sched_if.sv
// Requester-side bundle for alu_sched: two operation request channels plus the shared response.
// Latency: none (pure wiring).
// Backpressure: reqN_ready gates each request channel; the response path has none.
interface alu_sched_if #(
    parameter int word_width = 32,
    parameter int op_width   = 4,
    parameter int flag_width = 5
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [op_width-1:0]   req0_op;
    logic [word_width-1:0] req0_a;
    logic [word_width-1:0] req0_b;
    logic                  req0_cin;
    logic                  rsp0_valid;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [op_width-1:0]   req1_op;
    logic [word_width-1:0] req1_a;
    logic [word_width-1:0] req1_b;
    logic                  req1_cin;
    logic                  rsp1_valid;

    logic [word_width-1:0] rsp_result;
    logic [flag_width-1:0] rsp_flags;

    // Requester side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_cin,
        output req1_valid, req1_op, req1_a, req1_b, req1_cin,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_op, req1_a, req1_b, req1_cin,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one T1/T2/ALU datapath between two requesters.
// Latency: response pulse 3 cycles after the accept cycle; one operation per 4 cycles.
// Backpressure: ready only in IDLE for the granted requester; responses cannot be stalled.
module alu_sched #(
    parameter int word_width = 32,
    parameter int op_width   = 4,
    parameter int flag_width = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_sched_if.slave            bus,
    output logic                  busy,
    output logic                  t1_we,
    output logic                  t2_we,
    output logic [word_width-1:0] t1_in,
    output logic [word_width-1:0] t2_in,
    output logic                  t1_oe,
    output logic                  t2_oe,
    output logic                  alu_oe,
    output logic [op_width-1:0]   alu_opcode,
    output logic                  alu_carry,
    input  logic [word_width-1:0] alu_out,
    input  logic [flag_width-1:0] alu_flags
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

    state_t              state;
    logic                last_grant;   // index served most recently; loser of the next tie
    logic                grant_q;      // index that owns the operation in flight
    logic [op_width-1:0] op_q;
    logic                cin_q;

    logic                gnt_idx;
    logic                accept;

    // Arbitration: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        gnt_idx = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !gnt_idx;
    assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  gnt_idx;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign busy           = (state != IDLE);

    // Sequencer: latch the winning op, then drive registered controls through LOAD/EXEC/DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            grant_q        <= 1'b0;
            op_q           <= '0;
            cin_q          <= 1'b0;
            t1_we          <= 1'b0;
            t2_we          <= 1'b0;
            t1_in          <= '0;
            t2_in          <= '0;
            t1_oe          <= 1'b0;
            t2_oe          <= 1'b0;
            alu_oe         <= 1'b0;
            alu_opcode     <= '0;
            alu_carry      <= 1'b0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_flags  <= '0;
        end else begin
            // Controls are single-state pulses; result/flags hold until the next capture
            t1_we          <= 1'b0;
            t2_we          <= 1'b0;
            t1_in          <= '0;
            t2_in          <= '0;
            t1_oe          <= 1'b0;
            t2_oe          <= 1'b0;
            alu_oe         <= 1'b0;
            alu_opcode     <= '0;
            alu_carry      <= 1'b0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= LOAD;
                        grant_q    <= gnt_idx;
                        last_grant <= gnt_idx;
                        op_q       <= gnt_idx ? bus.req1_op  : bus.req0_op;
                        cin_q      <= gnt_idx ? bus.req1_cin : bus.req0_cin;
                        // Operands go straight into the LOAD-cycle write data registers
                        t1_we      <= 1'b1;
                        t2_we      <= 1'b1;
                        t1_in      <= gnt_idx ? bus.req1_a : bus.req0_a;
                        t2_in      <= gnt_idx ? bus.req1_b : bus.req0_b;
                    end
                end
                LOAD: begin
                    state      <= EXEC;
                    t1_oe      <= 1'b1;
                    t2_oe      <= 1'b1;
                    alu_oe     <= 1'b1;
                    alu_opcode <= op_q;
                    alu_carry  <= cin_q;
                end
                EXEC: begin
                    state          <= DONE;
                    bus.rsp_result <= alu_out;
                    bus.rsp_flags  <= alu_flags;
                    bus.rsp0_valid <= !grant_q;
                    bus.rsp1_valid <= grant_q;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;
    localparam int W   = 32;
    localparam int OPW = 4;
    localparam int FW  = 5;
    localparam logic [OPW-1:0] OP_ADD = 4'd1;
    localparam logic [OPW-1:0] OP_SUB = 4'd2;
    localparam logic [OPW-1:0] OP_AND = 4'd3;
    localparam logic [OPW-1:0] OP_OR  = 4'd4;
    localparam logic [OPW-1:0] OP_XOR = 4'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_sched_if #(.word_width(W), .op_width(OPW), .flag_width(FW)) bus ();

    logic           busy, t1_we, t2_we, t1_oe, t2_oe, alu_oe, alu_carry;
    logic [W-1:0]   t1_in, t2_in, alu_out;
    logic [OPW-1:0] alu_opcode;
    logic [FW-1:0]  alu_flags;

    alu_sched #(.word_width(W), .op_width(OPW), .flag_width(FW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .busy       (busy),
        .t1_we      (t1_we),
        .t2_we      (t2_we),
        .t1_in      (t1_in),
        .t2_in      (t2_in),
        .t1_oe      (t1_oe),
        .t2_oe      (t2_oe),
        .alu_oe     (alu_oe),
        .alu_opcode (alu_opcode),
        .alu_carry  (alu_carry),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags)
    );

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference ALU: flags = {parity, overflow, negative, zero, carry}
    function automatic logic [FW+W-1:0] alu_fn(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic cin);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a;
        endcase
        return {^r, v, r[W-1], (r == '0), c, r};
    endfunction

    // External T1/T2 registers and ALU that the scheduler drives
    logic [W-1:0] t1_q, t2_q;
    always @(posedge clk) begin
        if (t1_we) t1_q <= t1_in;
        if (t2_we) t2_q <= t2_in;
    end
    always_comb begin
        {alu_flags, alu_out} = alu_oe ? alu_fn(alu_opcode, t1_oe ? t1_q : '0, t2_oe ? t2_q : '0, alu_carry)
                                      : '0;
    end

    typedef struct {
        logic         idx;
        logic [W-1:0] res;
        logic [FW-1:0] flg;
    } exp_t;
    exp_t sb_q[$];
    exp_t e_acc, e_rsp;

    // Scoreboard: push on accept, pop on response; also protocol invariants
    always @(negedge clk) begin
        #4;
        if (rst) begin
            sb_q.delete();
        end else begin
            checks++;
            if (bus.req0_ready && bus.req1_ready) begin
                errors++;
                $display("FAIL both_ready: req0_ready=%b req1_ready=%b, at most one allowed", bus.req0_ready, bus.req1_ready);
            end
            checks++;
            if ((bus.req0_ready || bus.req1_ready) && busy) begin
                errors++;
                $display("FAIL ready_not_idle: ready high while busy=%b", busy);
            end
            if (bus.req0_valid && bus.req0_ready) begin
                e_acc.idx = 1'b0;
                {e_acc.flg, e_acc.res} = alu_fn(bus.req0_op, bus.req0_a, bus.req0_b, bus.req0_cin);
                sb_q.push_back(e_acc);
            end else if (bus.req1_valid && bus.req1_ready) begin
                e_acc.idx = 1'b1;
                {e_acc.flg, e_acc.res} = alu_fn(bus.req1_op, bus.req1_a, bus.req1_b, bus.req1_cin);
                sb_q.push_back(e_acc);
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                checks++;
                if (bus.rsp0_valid && bus.rsp1_valid) begin
                    errors++;
                    $display("FAIL rsp_both: rsp0_valid and rsp1_valid both high");
                end else if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: rsp%0d pulse result=%h with nothing outstanding",
                             bus.rsp1_valid, bus.rsp_result);
                end else begin
                    e_rsp = sb_q.pop_front();
                    if (bus.rsp1_valid !== e_rsp.idx || bus.rsp_result !== e_rsp.res || bus.rsp_flags !== e_rsp.flg) begin
                        errors++;
                        $display("FAIL rsp_data: got idx=%0d result=%h flags=%b, expected idx=%0d result=%h flags=%b",
                                 bus.rsp1_valid, bus.rsp_result, bus.rsp_flags, e_rsp.idx, e_rsp.res, e_rsp.flg);
                    end
                end
            end
        end
    end

    task automatic clear_reqs;
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        clear_reqs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++;
        if ({busy, t1_we, t2_we, t1_oe, t2_oe, alu_oe, alu_carry, bus.rsp0_valid, bus.rsp1_valid} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/we/oe/carry/rsp=%b, expected all 0",
                     {busy, t1_we, t2_we, t1_oe, t2_oe, alu_oe, alu_carry, bus.rsp0_valid, bus.rsp1_valid});
        end
        checks++;
        if (t1_in !== '0 || t2_in !== '0 || alu_opcode !== '0 || bus.rsp_result !== '0 || bus.rsp_flags !== '0) begin
            errors++;
            $display("FAIL reset_data: t1_in=%h t2_in=%h opcode=%h result=%h flags=%b, expected 0",
                     t1_in, t2_in, alu_opcode, bus.rsp_result, bus.rsp_flags);
        end
        #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tie: ready0=%b ready1=%b, expected 1 0", bus.req0_ready, bus.req1_ready);
        end
        clear_reqs();
    endtask

    task automatic test_single;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd5; bus.req0_b = 32'd6; bus.req0_cin = 1'b0;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: ready0=%b ready1=%b, expected 1 0", bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        checks++;
        if ({busy, t1_we, t2_we, t1_oe, t2_oe, alu_oe} !== 6'b111000 || t1_in !== 32'd5 || t2_in !== 32'd6) begin
            errors++;
            $display("FAIL single_load: busy/we1/we2/oe1/oe2/aluoe=%b t1_in=%0d t2_in=%0d, expected 111000 5 6",
                     {busy, t1_we, t2_we, t1_oe, t2_oe, alu_oe}, t1_in, t2_in);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({t1_we, t2_we, t1_oe, t2_oe, alu_oe, alu_carry} !== 6'b001110 || alu_opcode !== OP_ADD || t1_in !== '0) begin
            errors++;
            $display("FAIL single_exec: we1/we2/oe1/oe2/aluoe/carry=%b opcode=%0d t1_in=%h, expected 001110 %0d 0",
                     {t1_we, t2_we, t1_oe, t2_oe, alu_oe, alu_carry}, alu_opcode, t1_in, OP_ADD);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp_result !== 32'd11 || alu_oe !== 1'b0) begin
            errors++;
            $display("FAIL single_done: rsp0=%b rsp1=%b result=%0d alu_oe=%b, expected 1 0 11 0",
                     bus.rsp0_valid, bus.rsp1_valid, bus.rsp_result, alu_oe);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp0_valid !== 1'b0 || busy !== 1'b0 || bus.rsp_result !== 32'd11) begin
            errors++;
            $display("FAIL single_hold: rsp0=%b busy=%b result=%0d, expected 0 0 11",
                     bus.rsp0_valid, busy, bus.rsp_result);
        end
    endtask

    task automatic test_tie;
        int first, r0t, r1t;
        logic [W-1:0] res0, res1;
        logic drop0, drop1;
        first = -1; r0t = -1; r1t = -1; res0 = '0; res1 = '0;
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd1;  bus.req0_b = 32'd2;
        bus.req1_valid = 1'b1; bus.req1_op = OP_ADD; bus.req1_a = 32'd10; bus.req1_b = 32'd20;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (bus.req0_ready && first < 0) first = 0;
            if (bus.req1_ready && first < 0) first = 1;
            drop0 = bus.req0_ready;
            drop1 = bus.req1_ready;
            if (bus.rsp0_valid) begin r0t = cyc_cnt; res0 = bus.rsp_result; end
            if (bus.rsp1_valid) begin r1t = cyc_cnt; res1 = bus.rsp_result; end
            @(negedge clk);
            if (drop0) bus.req0_valid = 1'b0;
            if (drop1) bus.req1_valid = 1'b0;
        end
        checks++;
        if (first !== 0) begin
            errors++;
            $display("FAIL tie_first: first grant=%0d, expected 0", first);
        end
        checks++;
        if (r0t < 0 || r1t < 0 || (r1t - r0t) != 4) begin
            errors++;
            $display("FAIL tie_spacing: rsp0 at %0d rsp1 at %0d, expected both present and 4 apart", r0t, r1t);
        end
        checks++;
        if (res0 !== 32'd3 || res1 !== 32'd30) begin
            errors++;
            $display("FAIL tie_results: res0=%0d res1=%0d, expected 3 30", res0, res1);
        end
        clear_reqs();
    endtask

    task automatic test_contention;
        int n, idle_run;
        logic seen_busy, chg0, chg1;
        logic g [8];
        n = 0; idle_run = 0; seen_busy = 1'b0; chg0 = 1'b0; chg1 = 1'b0;
        for (int i = 0; i < 8; i++) g[i] = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_cin = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_op = OP_SUB; bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_cin = 1'b0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            #1;
            if (!busy) begin
                idle_run++;
            end else begin
                if (seen_busy && idle_run != 0) begin
                    checks++;
                    if (idle_run != 1) begin
                        errors++;
                        $display("FAIL contention_gap: busy low for %0d cycles between ops, expected 1", idle_run);
                    end
                end
                seen_busy = 1'b1;
                idle_run = 0;
            end
            if (bus.req0_ready) begin g[n] = 1'b0; n++; chg0 = 1'b1; end
            else if (bus.req1_ready) begin g[n] = 1'b1; n++; chg1 = 1'b1; end
            @(negedge clk);
            if (chg0) begin
                bus.req0_op = 4'($urandom_range(1, 5)); bus.req0_a = $urandom; bus.req0_b = $urandom;
                bus.req0_cin = 1'($urandom_range(0, 1)); chg0 = 1'b0;
            end
            if (chg1) begin
                bus.req1_op = 4'($urandom_range(1, 5)); bus.req1_a = $urandom; bus.req1_b = $urandom;
                bus.req1_cin = 1'($urandom_range(0, 1)); chg1 = 1'b0;
            end
            if (n == 8) clear_reqs();
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL contention_count: %0d accepts, expected 8", n);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (g[i] !== 1'(i % 2)) begin
                errors++;
                $display("FAIL contention_order: grant %0d went to %0d, expected %0d", i, g[i], i % 2);
            end
        end
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL contention_drain: %0d responses missing, expected 0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int acc_t [2];
        logic chg;
        n = 0; chg = 1'b0; acc_t[0] = 0; acc_t[1] = 0;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_op = OP_XOR; bus.req0_a = 32'hA5A5_0F0F; bus.req0_b = 32'h0FF0_1234;
        for (int c = 0; c < 20 && n < 2; c++) begin
            #1;
            if (bus.req0_ready) begin acc_t[n] = cyc_cnt; n++; chg = 1'b1; end
            @(negedge clk);
            if (chg) begin bus.req0_op = OP_OR; bus.req0_a = 32'h0000_8001; chg = 1'b0; end
            if (n == 2) clear_reqs();
        end
        checks++;
        if (n != 2 || (acc_t[1] - acc_t[0]) != 4) begin
            errors++;
            $display("FAIL b2b_reaccept: %0d accepts, spacing %0d, expected 2 accepts 4 apart", n, acc_t[1] - acc_t[0]);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_operand_change;
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_op = OP_SUB; bus.req1_a = 32'd7; bus.req1_b = 32'd1; bus.req1_cin = 1'b0;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL opchg_ready: req1_ready=%b, expected 1", bus.req1_ready);
        end
        @(negedge clk);
        bus.req1_valid = 1'b0; bus.req1_a = 32'd99; bus.req1_op = OP_ADD;
        #1;
        checks++;
        if (t1_in !== 32'd7 || t2_in !== 32'd1) begin
            errors++;
            $display("FAIL opchg_load: t1_in=%0d t2_in=%0d, expected 7 1", t1_in, t2_in);
        end
        @(negedge clk);
        #1;
        checks++;
        if (alu_opcode !== OP_SUB) begin
            errors++;
            $display("FAIL opchg_opcode: alu_opcode=%0d, expected %0d", alu_opcode, OP_SUB);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp_result !== 32'd6) begin
            errors++;
            $display("FAIL opchg_result: rsp1=%b rsp0=%b result=%0d, expected 1 0 6",
                     bus.rsp1_valid, bus.rsp0_valid, bus.rsp_result);
        end
        clear_reqs();
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd3; bus.req0_b = 32'd4;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (alu_oe !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_exec: alu_oe=%b when reset raised, expected 1", alu_oe);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, t1_we, t2_we, t1_oe, t2_oe, alu_oe, alu_carry, bus.rsp0_valid, bus.rsp1_valid} !== 9'b0 ||
            t1_in !== '0 || t2_in !== '0 || alu_opcode !== '0) begin
            errors++;
            $display("FAIL abort_ctrl: busy/we/oe/carry/rsp=%b t1_in=%h t2_in=%h opcode=%h, expected all 0",
                     {busy, t1_we, t2_we, t1_oe, t2_oe, alu_oe, alu_carry, bus.rsp0_valid, bus.rsp1_valid},
                     t1_in, t2_in, alu_opcode);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_rsp: rsp0=%b busy=%b, expected 0 0", bus.rsp0_valid, busy);
        end
        #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_op = OP_ADD; bus.req1_a = 32'd20; bus.req1_b = 32'd22; bus.req1_cin = 1'b0;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_last_grant: ready0=%b ready1=%b, expected 1 0", bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_req1_ready: req1_ready=%b, expected 1", bus.req1_ready);
        end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp_result !== 32'd42) begin
            errors++;
            $display("FAIL abort_req1_result: rsp1=%b result=%0d, expected 1 42", bus.rsp1_valid, bus.rsp_result);
        end
        clear_reqs();
        @(negedge clk);
    endtask

    task automatic test_carry_flags;
        logic [FW-1:0] fl_exec;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'd1; bus.req0_cin = 1'b0;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        #1;
        fl_exec = alu_flags;
        checks++;
        if (alu_oe !== 1'b1 || alu_carry !== 1'b0) begin
            errors++;
            $display("FAIL carry_exec: alu_oe=%b alu_carry=%b, expected 1 0", alu_oe, alu_carry);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp_result !== '0 || bus.rsp_flags !== 5'b00011) begin
            errors++;
            $display("FAIL carry_result: rsp0=%b result=%h flags=%b, expected 1 0 00011",
                     bus.rsp0_valid, bus.rsp_result, bus.rsp_flags);
        end
        checks++;
        if (bus.rsp_flags !== fl_exec) begin
            errors++;
            $display("FAIL carry_flags_capture: rsp_flags=%b, ALU flags in EXEC were %b", bus.rsp_flags, fl_exec);
        end
        clear_reqs();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        clear_reqs();
        test_reset();
        test_single();
        test_tie();
        test_contention();
        test_back_to_back();
        test_operand_change();
        test_reset_midop();
        test_carry_flags();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL final_outstanding: %0d responses never arrived, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
